// File: rtl/unigate_pkg.sv
// unigate_pkg: shared types and constants for the unigate reference-mode
// sequencer and loaders.
//   - state_e       sweeper FSM states
//   - ref_word_t    27-bit reference input word layout (MSB to LSB)
//   - REF_*, *_LSB  field positions and the fixed tag/flag values
package unigate_pkg;

    localparam int unsigned NUM_VECTORS  = 16;
    localparam int unsigned REF_W        = 27;
    localparam int unsigned PIN_W        = 4;
    localparam int unsigned FUNC_W       = 16;
    localparam int unsigned SEL_W        = 2;
    localparam int unsigned TAG_W        = 4;
    localparam int unsigned OUT_W        = 6;
    localparam int unsigned OBS_W        = 3;
    localparam int unsigned MM_W         = 5;
    localparam int unsigned SETTLE_W     = 8;
    localparam int unsigned CAP_ALL_W    = OUT_W * NUM_VECTORS;

    localparam logic [TAG_W-1:0] REF_TAG = 4'b0011;
    localparam int unsigned REF_FLAG_BIT = 26;
    localparam int unsigned PIN_LSB      = 22;
    localparam int unsigned FUNC_LSB     = 6;
    localparam int unsigned SEL_LSB      = 4;
    localparam int unsigned TAG_LSB      = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic              flag;
        logic [PIN_W-1:0]  pin;
        logic [FUNC_W-1:0] func;
        logic [SEL_W-1:0]  sel;
        logic [TAG_W-1:0]  tag;
    } ref_word_t;

endpackage

// File: rtl/unigate_ref_pack.sv
// unigate_ref_pack: combinational packer producing the reference-mode input
// word for the unigate core.
//   pin        in   4  pin combination under test
//   func       in  16  truth table being exercised
//   sel        in   2  gate-size select
//   ref_word_c out 27  {1, pin, func, sel, 4'b0011}
module unigate_ref_pack
    import unigate_pkg::*;
(
    input  logic [PIN_W-1:0]  pin,
    input  logic [FUNC_W-1:0] func,
    input  logic [SEL_W-1:0]  sel,
    output logic [REF_W-1:0]  ref_word_c
);

    // Field placement driven by the package positions so loaders stay in sync.
    always_comb begin
        ref_word_c                          = '0;
        ref_word_c[REF_FLAG_BIT]            = 1'b1;
        ref_word_c[PIN_LSB  +: PIN_W]       = pin;
        ref_word_c[FUNC_LSB +: FUNC_W]      = func;
        ref_word_c[SEL_LSB  +: SEL_W]       = sel;
        ref_word_c[TAG_LSB  +: TAG_W]       = REF_TAG;
    end

endmodule

// File: rtl/unigate_ref_sweeper.sv
// unigate_ref_sweeper: walks all 16 pin combinations of the unigate core in
// reference mode, samples one chosen output bit per combination, rebuilds the
// observed truth table and counts mismatches against the expected one.
// Optional macro UNIGATE_SWEEP_ALL_EN adds capture_all_o (all 6 outputs per pin).
//   wb_clk_i        in   1  clock
//   wb_rst_i        in   1  synchronous active-high reset
//   start_i         in   1  sweep request, honoured only when idle
//   sel_i           in   2  gate-size select (latched at start)
//   func_i          in  16  expected truth table (latched at start)
//   obs_idx_i       in   3  observed output bit index (latched at start)
//   ucomb_in_o      out 27  registered core input drive
//   ucomb_out_i     in   6  core outputs
//   busy_o          out  1  sweep in progress, through the done cycle
//   done_o          out  1  completion pulse
//   captured_o      out 16  observed truth table
//   mismatch_cnt_o  out  5  entries differing from func
//   pass_o          out  1  no mismatches, valid from done_o onward
//   capture_all_o   out 96  (UNIGATE_SWEEP_ALL_EN) full outputs, 6 bits per pin
module unigate_ref_sweeper
    import unigate_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic [SEL_W-1:0]     sel_i,
    input  logic [FUNC_W-1:0]    func_i,
    input  logic [OBS_W-1:0]     obs_idx_i,
    output logic [REF_W-1:0]     ucomb_in_o,
    input  logic [OUT_W-1:0]     ucomb_out_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [FUNC_W-1:0]    captured_o,
    output logic [MM_W-1:0]      mismatch_cnt_o,
`ifdef UNIGATE_SWEEP_ALL_EN
    output logic [CAP_ALL_W-1:0] capture_all_o,
`endif
    output logic                 pass_o
);

    state_e               state_q, state_d;
    logic [PIN_W-1:0]     pin_q, pin_d;
    logic [SETTLE_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [FUNC_W-1:0]    func_q, func_d;
    logic [OBS_W-1:0]     obs_q, obs_d;
    logic [REF_W-1:0]     ucomb_in_d;
    logic                 busy_d, done_d, pass_d;
    logic [FUNC_W-1:0]    captured_d;
    logic [MM_W-1:0]      mismatch_d;
    logic [REF_W-1:0]     ref_word_c;
    logic [7:0]           out_ext_c;
    logic                 obs_bit_c;
`ifdef UNIGATE_SWEEP_ALL_EN
    logic [CAP_ALL_W-1:0] cap_all_d;
`endif

    // Reference word for the current pin from the latched sel/func.
    unigate_ref_pack u_pack (
        .pin        (pin_q),
        .func       (func_q),
        .sel        (sel_q),
        .ref_word_c (ref_word_c)
    );

    // Indices 6 and 7 fall on zero-padding, so they read as 0.
    assign out_ext_c = {2'b00, ucomb_out_i};
    assign obs_bit_c = out_ext_c[obs_q];

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        pin_d      = pin_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        func_d     = func_q;
        obs_d      = obs_q;
        ucomb_in_d = ucomb_in_o;
        busy_d     = busy_o;
        done_d     = 1'b0;
        pass_d     = pass_o;
        captured_d = captured_o;
        mismatch_d = mismatch_cnt_o;
`ifdef UNIGATE_SWEEP_ALL_EN
        cap_all_d  = capture_all_o;
`endif
        case (state_q)
            ST_IDLE: begin
                ucomb_in_d = '0;
                busy_d     = 1'b0;
                // busy_o is still high during the done cycle, which blocks a
                // start arriving right after DONE.
                if (start_i && !busy_o) begin
                    sel_d      = sel_i;
                    func_d     = func_i;
                    obs_d      = obs_idx_i;
                    captured_d = '0;
                    mismatch_d = '0;
                    pass_d     = 1'b0;
                    pin_d      = '0;
                    busy_d     = 1'b1;
`ifdef UNIGATE_SWEEP_ALL_EN
                    cap_all_d  = '0;
`endif
                    state_d    = ST_APPLY;
                end
            end
            ST_APPLY: begin
                ucomb_in_d = ref_word_c;
                cnt_d      = SETTLE_W'(SETTLE_CYCLES - 1);
                busy_d     = 1'b1;
                state_d    = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
            end
            ST_SAMPLE: begin
                busy_d             = 1'b1;
                captured_d[pin_q]  = obs_bit_c;
                if (obs_bit_c != func_q[pin_q]) begin
                    mismatch_d = mismatch_cnt_o + MM_W'(1);
                end
`ifdef UNIGATE_SWEEP_ALL_EN
                for (int k = 0; k < int'(NUM_VECTORS); k++) begin
                    if (pin_q == PIN_W'(k)) begin
                        cap_all_d[OUT_W*k +: OUT_W] = ucomb_out_i;
                    end
                end
`endif
                if (pin_q == PIN_W'(NUM_VECTORS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    pin_d   = pin_q + PIN_W'(1);
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b1;
                pass_d     = (mismatch_cnt_o == '0);
                ucomb_in_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q        <= ST_IDLE;
            pin_q          <= '0;
            cnt_q          <= '0;
            sel_q          <= '0;
            func_q         <= '0;
            obs_q          <= '0;
            ucomb_in_o     <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            captured_o     <= '0;
            mismatch_cnt_o <= '0;
`ifdef UNIGATE_SWEEP_ALL_EN
            capture_all_o  <= '0;
`endif
        end else begin
            state_q        <= state_d;
            pin_q          <= pin_d;
            cnt_q          <= cnt_d;
            sel_q          <= sel_d;
            func_q         <= func_d;
            obs_q          <= obs_d;
            ucomb_in_o     <= ucomb_in_d;
            busy_o         <= busy_d;
            done_o         <= done_d;
            pass_o         <= pass_d;
            captured_o     <= captured_d;
            mismatch_cnt_o <= mismatch_d;
`ifdef UNIGATE_SWEEP_ALL_EN
            capture_all_o  <= cap_all_d;
`endif
        end
    end

endmodule

// File: tb/tb_unigate_ref_sweeper.sv
// Self-checking bench for unigate_ref_sweeper: a behavioural core model (lookup
// tables per output bit, one register plus an adjustable extra delay) answers
// the reference words, and expected tables/counts come from the LUT contents.
module tb_unigate_ref_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: SETTLE_CYCLES = 4
    logic        start0 = 1'b0;
    logic [1:0]  sel0 = '0;
    logic [15:0] func0 = '0;
    logic [2:0]  obs0 = '0;
    logic [26:0] uin0;
    logic [5:0]  uout0;
    logic        busy0, done0, pass0;
    logic [15:0] cap0;
    logic [4:0]  mm0;
    // Instance 1: SETTLE_CYCLES = 1
    logic        start1 = 1'b0;
    logic [26:0] uin1;
    logic [5:0]  uout1;
    logic        busy1, done1, pass1;
    logic [15:0] cap1;
    logic [4:0]  mm1;
`ifdef UNIGATE_SWEEP_ALL_EN
    logic [95:0] call0, call1;
`endif

    unigate_ref_sweeper #(.SETTLE_CYCLES(4)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start0), .sel_i(sel0),
        .func_i(func0), .obs_idx_i(obs0), .ucomb_in_o(uin0), .ucomb_out_i(uout0),
        .busy_o(busy0), .done_o(done0), .captured_o(cap0), .mismatch_cnt_o(mm0),
`ifdef UNIGATE_SWEEP_ALL_EN
        .capture_all_o(call0),
`endif
        .pass_o(pass0)
    );

    unigate_ref_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start1), .sel_i(2'b10),
        .func_i(16'h8000), .obs_idx_i(3'd3), .ucomb_in_o(uin1), .ucomb_out_i(uout1),
        .busy_o(busy1), .done_o(done1), .captured_o(cap1), .mismatch_cnt_o(mm1),
`ifdef UNIGATE_SWEEP_ALL_EN
        .capture_all_o(call1),
`endif
        .pass_o(pass1)
    );

    // Core model: output bit b for pin p is lut[b][p] when refmode flag is set.
    logic [15:0] lut0 [6];
    logic [15:0] lut1 [6];
    int          dly0 = 0;
    int          dly1 = 0;
    logic [26:0] pipe0 [8];
    logic [26:0] pipe1 [8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            pipe0[i] = '0;
            pipe1[i] = '0;
        end
        for (int b = 0; b < 6; b++) begin
            lut0[b] = '0;
            lut1[b] = '0;
        end
    end

    always @(posedge clk) begin
        pipe0[0] <= uin0;
        pipe1[0] <= uin1;
        for (int i = 1; i < 8; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end

    always_comb begin
        uout0 = '0;
        if (pipe0[dly0][26])
            for (int b = 0; b < 6; b++) uout0[b] = lut0[b][pipe0[dly0][25:22]];
    end

    always_comb begin
        uout1 = '0;
        if (pipe1[dly1][26])
            for (int b = 0; b < 6; b++) uout1[b] = lut1[b][pipe1[dly1][25:22]];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_cap(input logic [2:0] o);
        return (o < 3'd6) ? lut0[o] : 16'h0000;
    endfunction

    function automatic int popcnt(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    // One sweep on dut0; c counts edges after the accepting edge.
    task automatic sweep0(input logic [1:0] s, input logic [15:0] f, input logic [2:0] o,
                          input bit pokes, input bit do_rst,
                          output int done_cyc, output int done_cnt);
        logic [26:0] w5;
        sel0 = s; func0 = f; obs0 = o;
        w5 = {1'b1, 4'd5, f, s, 4'b0011};
        done_cyc = -1; done_cnt = 0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            @(posedge clk); #1;
            start0 = pokes && (c == 10 || c == 96 || c == 97);
            if (done0) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 1) check("busy_after_start", 32'(busy0), 32'd1);
            if (c == 33 && !do_rst) check("ref_word_pin5", 32'(uin0), 32'(w5));
            if (do_rst && c == 44) rst = 1'b1;
            if (do_rst && c == 45) begin
                check("rst_mid_uin", 32'(uin0), 32'd0);
                check("rst_mid_busy", 32'(busy0), 32'd0);
                check("rst_mid_cap", 32'(cap0), 32'd0);
                rst = 1'b0;
            end
        end
        start0 = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] ecap, input int emm);
        check({tag, "_cap"}, 32'(cap0), 32'(ecap));
        check({tag, "_mm"}, 32'(mm0), 32'(emm));
        check({tag, "_pass"}, 32'(pass0), 32'(emm == 0));
        check({tag, "_idle"}, 32'(busy0), 32'd0);
    endtask

    int dc, dn;
    logic [15:0] ecap, rf;
    logic [2:0]  ro;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_uin", 32'(uin0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_cap", 32'(cap0), 32'd0);
        check("rst_mm", 32'(mm0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // AND4 with busy pokes: latency, single done, hold afterwards
        for (int b = 0; b < 6; b++) lut0[b] = 16'($urandom);
        lut0[3] = 16'h8000; dly0 = 0;
        sweep0(2'b10, 16'h8000, 3'd3, 1'b1, 1'b0, dc, dn);
        check("and4_latency", 32'(dc), 32'd97);
        check("and4_done_count", 32'(dn), 32'd1);
        expect_result("and4", 16'h8000, 0);

        // Model delayed by SETTLE_CYCLES-1 still passes
        dly0 = 3;
        sweep0(2'b10, 16'h8000, 3'd3, 1'b0, 1'b0, dc, dn);
        expect_result("and4_dly3", 16'h8000, 0);

        // Model delayed by SETTLE_CYCLES samples the previous word
        dly0 = 4;
        sweep0(2'b10, 16'h8000, 3'd3, 1'b0, 1'b0, dc, dn);
        expect_result("and4_dly4", 16'h0000, 1);
        dly0 = 0;

        // XOR4 stuck-at-0
        lut0[3] = 16'h0000;
        sweep0(2'b11, 16'h6996, 3'd3, 1'b0, 1'b0, dc, dn);
        expect_result("xor4_sa0", 16'h0000, 8);

        // Reset mid-sweep (pin 7), then a fresh sweep completes
        lut0[3] = 16'h8000;
        sweep0(2'b10, 16'h8000, 3'd3, 1'b0, 1'b1, dc, dn);
        check("rst_mid_no_done", 32'(dn), 32'd0);
        sweep0(2'b10, 16'h8000, 3'd3, 1'b0, 1'b0, dc, dn);
        check("after_rst_latency", 32'(dc), 32'd97);
        expect_result("after_rst", 16'h8000, 0);

        // Invalid observation index reads 0
        for (int b = 0; b < 6; b++) lut0[b] = 16'hFFFF;
        sweep0(2'b01, 16'h00FF, 3'd6, 1'b0, 1'b0, dc, dn);
        expect_result("obs6", 16'h0000, 8);

        // Randomized tables, functions and indices
        for (int it = 0; it < 6; it++) begin
            for (int b = 0; b < 6; b++) lut0[b] = 16'($urandom);
            rf = 16'($urandom);
            ro = 3'($urandom_range(0, 7));
            dly0 = $urandom_range(0, 3);
            ecap = exp_cap(ro);
            sweep0(2'($urandom), rf, ro, 1'b0, 1'b0, dc, dn);
            check("rand_done_count", 32'(dn), 32'd1);
            expect_result("rand", ecap, popcnt(ecap ^ rf));
`ifdef UNIGATE_SWEEP_ALL_EN
            for (int k = 0; k < 16; k++) begin
                logic [5:0] ev;
                for (int b = 0; b < 6; b++) ev[b] = lut0[b][k];
                check("rand_capture_all", 32'(call0[6*k +: 6]), 32'(ev));
            end
`endif
        end

        // SETTLE_CYCLES=1 instance: undelayed model passes, 1-cycle delay fails
        lut1[3] = 16'h8000;
        for (int d = 0; d < 2; d++) begin
            dly1 = d;
            dc = -1;
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            for (int c = 1; c <= 60; c++) begin
                @(posedge clk); #1;
                if (done1 && dc < 0) dc = c;
            end
            check("s1_latency", 32'(dc), 32'd49);
            check("s1_cap", 32'(cap1), (d == 0) ? 32'h8000 : 32'h0);
            check("s1_mm", 32'(mm1), (d == 0) ? 32'd0 : 32'd1);
            check("s1_pass", 32'(pass1), (d == 0) ? 32'd1 : 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unigate_ref_sweeper.md
Name: unigate_ref_sweeper

Overview:
- On-chip sequencer that drives the unigate combinational core in reference mode and reads its outputs back.
- On start, it walks all 16 pin combinations for a given sel/func pair. For each one it applies the 27-bit reference input word, waits a settle interval, and samples one chosen output bit.
- It rebuilds the observed 16-entry truth table and counts mismatches against func.
- It sits between a host or loader and the 27-in/6-out unigate core, and replaces an external tester for self-check.

Parameters:
- SETTLE_CYCLES, 4, cycles waited after applying a vector before sampling; legal range 1..255.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request a sweep; sampled only in IDLE.
- sel_i  in  2  gate-size select, latched at start.
- func_i  in  16  expected truth table, latched at start; bit k is the expected value for pin==k.
- obs_idx_i  in  3  index of the core output bit to observe, latched at start.
- ucomb_in_o  out  27  registered drive to the core inputs.
- ucomb_out_i  in  6  core outputs.
- busy_o  out  1  high from the cycle after start is accepted through the DONE cycle.
- done_o  out  1  one-cycle pulse when the sweep completes.
- captured_o  out  16  observed truth table.
- mismatch_cnt_o  out  5  number of entries where captured differs from func, range 0..16.
- pass_o  out  1  mismatch_cnt_o==0; valid from done_o onward.

Behaviour:
- Reset values: ucomb_in_o=0, busy_o=0, done_o=0, captured_o=0, mismatch_cnt_o=0, pass_o=0. State is IDLE and pin=0.
- Reference word layout, MSB to LSB: {1'b1, pin[3:0], func[15:0], sel[1:0], 4'b0011}. Bit 26 is the refmode flag; the low nibble is the 0011 tag.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - ucomb_in_o=0.
  - When start_i=1: latch sel, func and obs_idx; clear captured, mismatch_cnt and pass; set pin=0; go to APPLY.
- APPLY (1 cycle): register the reference word for the current pin onto ucomb_in_o; load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): ucomb_in_o is held and the counter decrements. When the counter reaches 0, go to SAMPLE.
- SAMPLE (1 cycle):
  - bit = ucomb_out_i[obs_idx]; when obs_idx is 6 or 7, bit is 0.
  - captured[pin] <= bit.
  - If bit != func[pin], increment mismatch_cnt.
  - If pin==15, go to DONE; otherwise pin <= pin+1 and go to APPLY.
  - pin never wraps within a sweep.
- DONE (1 cycle): done_o=1, busy_o=1, pass_o updated; ucomb_in_o returns to 0; go to IDLE.
- Latency: done_o is high in the cycle that begins 16*(SETTLE_CYCLES+2)+1 edges after the edge that accepted start_i. For SETTLE_CYCLES=4 this is 97.
- start_i while busy is ignored, including during the DONE cycle.
- captured_o, mismatch_cnt_o and pass_o hold after DONE until the next accepted start.
- A reset asserted mid-sweep aborts the sweep and forces all reset values on the next edge. No done_o is produced.
- mismatch_cnt is 5 bits, so 16 mismatches is representable without saturation.

Optional Feature:
- Macro: UNIGATE_SWEEP_ALL_EN.
- With the macro defined:
  - Extra port capture_all_o (out, 96 bits). Slice [6*k+5:6*k] holds the full ucomb_out_i sampled for pin==k.
  - It is cleared at start, written in each SAMPLE state, and held after DONE.
- Without the macro: the port and its storage are absent, and all other behaviour is identical.

Decomposition:
- Package unigate_pkg holds:
  - the state enum;
  - REF_TAG=4'b0011;
  - REF_FLAG_BIT=26;
  - field-position constants for pin, func and sel;
  - the NUM_VECTORS=16 constant.
- Sub-module unigate_ref_pack is a combinational packer from pin/func/sel to the 27-bit reference word. It is reused by future loaders.
- FSM, settle counter and scoreboard stay in the top module.

Test Plan:
- AND4, model correct: sel=2'b10, func=16'h8000, obs_idx=3, SETTLE_CYCLES=4, bench model drives out[3]=&pin. Expect captured_o=16'h8000, mismatch_cnt_o=0, pass_o=1, done_o exactly 97 cycles after start, and ucomb_in_o for pin=5 equal to {1,0101,8000h,10,0011}.
- XOR4, stuck-at-0: func=16'h6996, model drives out[3]=0. Expect captured_o=0, mismatch_cnt_o=8, pass_o=0.
- Busy and hold: start_i pulsed at cycles 10 and 96 after the first start. Both are ignored; a single done_o pulse occurs, and the results hold for 20 idle cycles.
- Reset mid-sweep: wb_rst_i asserted while pin=7. Next cycle ucomb_in_o=0, busy_o=0, captured_o=0, and no done_o. A fresh start then completes normally.
- Invalid index: obs_idx=6 with func=16'h00FF. Expect captured_o=0 and mismatch_cnt_o=8.
- Settle timing: the model delays its output by SETTLE_CYCLES-1 cycles, which must still pass. A build with SETTLE_CYCLES=1 and a 1-cycle-delayed model must report mismatches.
